// File: rtl/testbasic19_types.sv
// rtl/testbasic19_types.sv - shared message, mode and arbiter-state types
package testbasic19_types;

    typedef enum logic {
        MODE_READ  = 1'b0,
        MODE_WRITE = 1'b1
    } mode_t;

    typedef struct packed {
        mode_t      mode;
        logic [7:0] x;
        logic [7:0] y;
    } CompoundType;

    typedef enum logic {
        IDLE = 1'b0,
        FULL = 1'b1
    } arb_state_t;

    localparam CompoundType COMPOUND_RESET = '{mode: MODE_READ, x: 8'd0, y: 8'd0};

endpackage

// File: rtl/compound_out_arbiter_if.sv
// rtl/compound_out_arbiter_if.sv - producer/consumer bundle around the shared b_out port
interface compound_out_arbiter_if #(
    parameter int NUM_REQ = 4
);
    import testbasic19_types::*;

    localparam int IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    CompoundType          req_in [NUM_REQ];
    logic [NUM_REQ-1:0]   req_in_notify;
    logic [NUM_REQ-1:0]   req_in_sync;
    CompoundType          b_out;
    logic                 b_out_notify;
    logic                 b_out_sync;
    logic [IDW-1:0]       grant_id;

    modport master (
        input  req_in, req_in_notify, b_out_sync,
        output req_in_sync, b_out, b_out_notify, grant_id
    );

    modport slave (
        output req_in, req_in_notify, b_out_sync,
        input  req_in_sync, b_out, b_out_notify, grant_id
    );

endinterface

// File: rtl/compound_rr_pick.sv
// rtl/compound_rr_pick.sv - combinational round-robin picker starting after last_grant
module compound_rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int IDW     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [IDW-1:0]     i_last_grant,
    output logic               o_valid,
    output logic [IDW-1:0]     o_index
);

    logic [IDW-1:0] w_idx;

    // Scan farthest-first so the nearest candidate after last_grant is the last one written
    always_comb begin
        o_valid = 1'b0;
        o_index = '0;
        w_idx   = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            w_idx = IDW'((int'(i_last_grant) + k) % NUM_REQ);
            if (i_req[w_idx]) begin
                o_valid = 1'b1;
                o_index = w_idx;
            end
        end
    end

endmodule

// File: rtl/compound_out_arbiter.sv
// rtl/compound_out_arbiter.sv - round-robin arbiter with one-deep output register
module compound_out_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter bit WRITE_FIRST = 1'b0
) (
    input  logic                   clk,
    input  logic                   rst,
    compound_out_arbiter_if.master bus
);
    import testbasic19_types::*;

    localparam int             IDW        = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [IDW-1:0] LAST_RESET = IDW'(NUM_REQ - 1);

    arb_state_t         r_state;
    CompoundType        r_b_out;
    logic [IDW-1:0]     r_grant_id;
    logic [IDW-1:0]     r_last_grant;

    logic [NUM_REQ-1:0] w_wr_mask;
    logic               w_all_valid;
    logic [IDW-1:0]     w_all_idx;
    logic               w_wr_valid;
    logic [IDW-1:0]     w_wr_idx;
    logic               w_pick_valid;
    logic [IDW-1:0]     w_pick_idx;
    logic               w_can_accept;
    logic               w_xfer;

    // Write-class candidates; notify gates mode so idle requesters' data is never looked at
    always_comb begin
        w_wr_mask = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_wr_mask[i] = bus.req_in_notify[i] & (bus.req_in[i].mode == MODE_WRITE);
        end
    end

    compound_rr_pick #(.NUM_REQ(NUM_REQ), .IDW(IDW)) u_pick_all (
        .i_req        (bus.req_in_notify),
        .i_last_grant (r_last_grant),
        .o_valid      (w_all_valid),
        .o_index      (w_all_idx)
    );

    compound_rr_pick #(.NUM_REQ(NUM_REQ), .IDW(IDW)) u_pick_wr (
        .i_req        (w_wr_mask),
        .i_last_grant (r_last_grant),
        .o_valid      (w_wr_valid),
        .o_index      (w_wr_idx)
    );

    // Any write candidate is also a candidate, so the full-mask valid covers both classes
    assign w_pick_valid = w_all_valid;
    assign w_pick_idx   = (WRITE_FIRST && w_wr_valid) ? w_wr_idx : w_all_idx;

    assign w_can_accept = (r_state == IDLE) | ((r_state == FULL) & bus.b_out_sync);
    assign w_xfer       = w_can_accept & w_pick_valid & ~rst;

    // One-hot consume strobe back to the winning producer in the transfer cycle
    always_comb begin
        bus.req_in_sync = '0;
        if (w_xfer) begin
            bus.req_in_sync[w_pick_idx] = 1'b1;
        end
    end

    // Output register: load on transfer, drain to IDLE when accepted with nothing waiting
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_b_out      <= COMPOUND_RESET;
            r_grant_id   <= '0;
            r_last_grant <= LAST_RESET;
        end else if (w_xfer) begin
            r_state      <= FULL;
            r_b_out      <= bus.req_in[w_pick_idx];
            r_grant_id   <= w_pick_idx;
            r_last_grant <= w_pick_idx;
        end else if ((r_state == FULL) && bus.b_out_sync) begin
            r_state      <= IDLE;
        end
    end

    assign bus.b_out        = r_b_out;
    assign bus.b_out_notify = (r_state == FULL);
    assign bus.grant_id     = r_grant_id;

endmodule

// File: tb/tb_compound_out_arbiter.sv
// tb/tb_compound_out_arbiter.sv - directed self-checking bench for compound_out_arbiter
module tb_compound_out_arbiter;
    import testbasic19_types::*;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_err;

    compound_out_arbiter_if #(.NUM_REQ(4)) bus0 ();
    compound_out_arbiter_if #(.NUM_REQ(4)) bus1 ();

    compound_out_arbiter #(.NUM_REQ(4), .WRITE_FIRST(1'b0)) u_dut_rr (
        .clk (clk),
        .rst (rst),
        .bus (bus0)
    );

    compound_out_arbiter #(.NUM_REQ(4), .WRITE_FIRST(1'b1)) u_dut_wf (
        .clk (clk),
        .rst (rst),
        .bus (bus1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic CompoundType mk(input mode_t m, input int x, input int y);
        CompoundType c;
        c.mode = m;
        c.x    = x[7:0];
        c.y    = y[7:0];
        return c;
    endfunction

    initial begin
        int exp_seq[5];
        n_cmp = 0;
        n_err = 0;
        exp_seq = '{0, 1, 2, 3, 0};

        rst = 1'b1;
        bus1.req_in_notify = '0;
        bus1.b_out_sync    = 1'b1;
        for (int i = 0; i < 4; i++) bus1.req_in[i] = COMPOUND_RESET;

        // 1. reset with random inputs
        for (int c = 0; c < 3; c++) begin
            for (int i = 0; i < 4; i++) bus0.req_in[i] = CompoundType'(17'($urandom));
            bus0.req_in_notify = 4'($urandom);
            bus0.b_out_sync    = 1'($urandom);
            #1;
            chk("rst_sync", 32'(bus0.req_in_sync), 32'h0);
            tick();
        end
        rst = 1'b0;
        bus0.req_in_notify = '0;
        bus0.b_out_sync    = 1'b0;
        #1;
        chk("rst_notify", 32'(bus0.b_out_notify), 32'h0);
        chk("rst_bout", 32'(bus0.b_out), 32'(COMPOUND_RESET));
        chk("rst_grant", 32'(bus0.grant_id), 32'h0);

        // 2. single request from req2
        bus0.req_in[2]     = mk(MODE_WRITE, 5, 1);
        bus0.req_in_notify = 4'b0100;
        bus0.b_out_sync    = 1'b1;
        #1;
        chk("single_sync", 32'(bus0.req_in_sync), 32'h4);
        tick();
        chk("single_bout", 32'(bus0.b_out), 32'(mk(MODE_WRITE, 5, 1)));
        chk("single_notify", 32'(bus0.b_out_notify), 32'h1);
        chk("single_grant", 32'(bus0.grant_id), 32'h2);
        bus0.req_in_notify = 4'b0000;
        tick();
        chk("single_drain", 32'(bus0.b_out_notify), 32'h0);

        // reset pulse so the round-robin pointer starts from requester 0 again
        rst = 1'b1;
        tick();
        rst = 1'b0;

        // 3. all four requesting continuously
        for (int i = 0; i < 4; i++) bus0.req_in[i] = mk(MODE_READ, i, i + 10);
        bus0.req_in_notify = 4'b1111;
        bus0.b_out_sync    = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("rr_grant", 32'(bus0.grant_id), 32'(exp_seq[k]));
            chk("rr_notify", 32'(bus0.b_out_notify), 32'h1);
            chk("rr_bout", 32'(bus0.b_out), 32'(mk(MODE_READ, exp_seq[k], exp_seq[k] + 10)));
        end

        // 4. backpressure while holding req0's message
        bus0.b_out_sync    = 1'b0;
        bus0.req_in_notify = 4'b1010;
        #1;
        chk("bp_sync0", 32'(bus0.req_in_sync), 32'h0);
        for (int c = 0; c < 5; c++) begin
            tick();
            chk("bp_bout", 32'(bus0.b_out), 32'(mk(MODE_READ, 0, 10)));
            chk("bp_grant", 32'(bus0.grant_id), 32'h0);
            chk("bp_sync", 32'(bus0.req_in_sync), 32'h0);
        end
        bus0.b_out_sync = 1'b1;
        #1;
        chk("bp_release_sync", 32'(bus0.req_in_sync), 32'h2);
        tick();
        chk("bp_release_grant", 32'(bus0.grant_id), 32'h1);
        chk("bp_release_bout", 32'(bus0.b_out), 32'(mk(MODE_READ, 1, 11)));

        // 6. reset while FULL and stalled
        bus0.b_out_sync    = 1'b0;
        bus0.req_in_notify = 4'b0011;
        rst = 1'b1;
        #1;
        chk("rstfull_sync", 32'(bus0.req_in_sync), 32'h0);
        tick();
        chk("rstfull_notify", 32'(bus0.b_out_notify), 32'h0);
        chk("rstfull_bout", 32'(bus0.b_out), 32'(COMPOUND_RESET));
        rst = 1'b0;
        bus0.b_out_sync = 1'b1;
        #1;
        chk("rstfull_tie_sync", 32'(bus0.req_in_sync), 32'h1);
        tick();
        chk("rstfull_tie_grant", 32'(bus0.grant_id), 32'h0);
        chk("rstfull_tie_bout", 32'(bus0.b_out), 32'(mk(MODE_READ, 0, 10)));
        bus0.req_in_notify = 4'b0000;

        // 5. write-first: write from req3 beats read from req0
        bus1.req_in[0]     = mk(MODE_READ, 1, 0);
        bus1.req_in[3]     = mk(MODE_WRITE, 9, 1);
        bus1.req_in_notify = 4'b1001;
        bus1.b_out_sync    = 1'b1;
        #1;
        chk("wf_sync1", 32'(bus1.req_in_sync), 32'h8);
        tick();
        chk("wf_grant1", 32'(bus1.grant_id), 32'h3);
        chk("wf_bout1", 32'(bus1.b_out), 32'(mk(MODE_WRITE, 9, 1)));
        bus1.req_in_notify = 4'b0001;
        #1;
        chk("wf_sync2", 32'(bus1.req_in_sync), 32'h1);
        tick();
        chk("wf_grant2", 32'(bus1.grant_id), 32'h0);
        chk("wf_bout2", 32'(bus1.b_out), 32'(mk(MODE_READ, 1, 0)));
        chk("wf_notify2", 32'(bus1.b_out_notify), 32'h1);
        bus1.req_in_notify = 4'b0000;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
